// File: rtl/adc128s_pkg.sv
// Shared constants and types for the ADC128S-style SPI A2D converter model.
package adc128s_pkg;

    localparam logic [2:0] CH_LFT     = 3'd0;
    localparam logic [2:0] CH_RGHT    = 3'd4;
    localparam logic [2:0] CH_STEER   = 3'd5;
    localparam logic [2:0] CH_BATT    = 3'd6;
    localparam int         FRAME_BITS = 16;

    typedef logic [11:0] adc_val_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Double-flop synchronizer with a history flop; emits single-clk rise/fall
// pulses derived only from the synchronized level.
module spi_edge_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic hist_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            hist_q <= RST_VAL;
        end else begin
            meta_q <= sig_i;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~hist_q;
    assign fall_o = ~sync_q & hist_q;

endmodule

// File: rtl/adc128s_fc.sv
// ADC128S-style 8-channel SPI A2D model: command in frame N selects the data in frame N+1.
// Optional protocol checking (short frames, nonzero command bits [15:14]) under ADC128S_FC_PROTO_CHK_EN.
module adc128s_fc
    import adc128s_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     SS_n,
    input  logic     SCLK,
    input  logic     MOSI,
    output logic     MISO,
    input  adc_val_t ld_cell_lft,
    input  adc_val_t ld_cell_rght,
    input  adc_val_t steerPot,
    input  adc_val_t batt
);

    localparam logic [4:0] FULL_CNT = 5'(FRAME_BITS);

    // Without the checker only the low 14 command bits are ever looked at, so
    // the receive register stops there; the channel field keeps its position.
`ifdef ADC128S_FC_PROTO_CHK_EN
    localparam int RX_W = FRAME_BITS;
`else
    localparam int RX_W = FRAME_BITS - 2;
`endif

    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    spi_edge_sync #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .sig_i(SCLK), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_edge_sync #(.RST_VAL(1'b1)) u_ss_sync (
        .clk(clk), .rst_n(rst_n), .sig_i(SS_n), .rise_o(ss_rise), .fall_o(ss_fall)
    );

    logic [15:0]     tx_shft_q, tx_shft_d;
    logic [RX_W-1:0] rx_shft_q, rx_shft_d;
    logic [4:0]      bit_cnt_q, bit_cnt_d;
    logic [2:0]      chnl_ptr_q, chnl_ptr_d;
    logic            ss_low_q, ss_low_d;
    adc_val_t        sel_val;

    always_comb begin
        sel_val = '0;
        case (chnl_ptr_q)
            CH_LFT:   sel_val = ld_cell_lft;
            CH_RGHT:  sel_val = ld_cell_rght;
            CH_STEER: sel_val = steerPot;
            CH_BATT:  sel_val = batt;
            default:  sel_val = '0;
        endcase
    end

    always_comb begin
        tx_shft_d  = tx_shft_q;
        rx_shft_d  = rx_shft_q;
        bit_cnt_d  = bit_cnt_q;
        chnl_ptr_d = chnl_ptr_q;
        ss_low_d   = ss_low_q;
        if (ss_fall) begin
            ss_low_d  = 1'b1;
            tx_shft_d = {4'h0, sel_val};
            rx_shft_d = '0;
            bit_cnt_d = '0;
        end else if (ss_rise) begin
            ss_low_d = 1'b0;
            if (bit_cnt_q == FULL_CNT) begin
                chnl_ptr_d = rx_shft_q[13:11];
            end
        end else if (ss_low_q) begin
            if (sclk_rise) begin
                rx_shft_d = {rx_shft_q[RX_W-2:0], MOSI};
                if (bit_cnt_q != FULL_CNT) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end
            // A fall before the first rise is the idle level, not a bit boundary.
            if (sclk_fall && (bit_cnt_q != 5'd0)) begin
                tx_shft_d = {tx_shft_q[14:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_shft_q  <= '0;
            rx_shft_q  <= '0;
            bit_cnt_q  <= '0;
            chnl_ptr_q <= '0;
            ss_low_q   <= 1'b0;
        end else begin
            tx_shft_q  <= tx_shft_d;
            rx_shft_q  <= rx_shft_d;
            bit_cnt_q  <= bit_cnt_d;
            chnl_ptr_q <= chnl_ptr_d;
            ss_low_q   <= ss_low_d;
        end
    end

    assign MISO = ss_low_q & tx_shft_q[15];

`ifdef ADC128S_FC_PROTO_CHK_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (ss_rise) begin
            if (bit_cnt_q != FULL_CNT) begin
                $error("ADC128S: short frame");
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end else if (rx_shft_q[15:14] != 2'b00) begin
                $error("ADC128S: command bits [15:14] not zero");
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_adc128s_fc.sv
// Self-checking bench for adc128s_fc: directed frames from the test plan plus
// randomized frames checked against a frame-level reference model.
module tb_adc128s_fc;

    localparam int HALF = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic [11:0] ld_cell_lft = '0;
    logic [11:0] ld_cell_rght = '0;
    logic [11:0] steerPot = '0;
    logic [11:0] batt = '0;

    int checks = 0;
    int errors = 0;

    logic [2:0] ptr_m;

    adc128s_fc dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .ld_cell_lft(ld_cell_lft), .ld_cell_rght(ld_cell_rght),
        .steerPot(steerPot), .batt(batt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ref_val(input logic [2:0] ch);
        case (ch)
            3'd0:    return ld_cell_lft;
            3'd4:    return ld_cell_rght;
            3'd5:    return steerPot;
            3'd6:    return batt;
            default: return 12'h000;
        endcase
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sclk_pulse();
        SCLK = 1'b1;
        wait_clk(HALF);
        SCLK = 1'b0;
        wait_clk(HALF);
    endtask

    // Mode-0 master: MOSI set before each rise, MISO sampled at the rise.
    task automatic spi_frame(input logic [15:0] cmd, input int nrise, output logic [15:0] resp);
        resp = '0;
        SS_n = 1'b0;
        MOSI = cmd[15];
        wait_clk(HALF);
        for (int i = 0; i < nrise; i++) begin
            SCLK = 1'b1;
            resp[15-i] = MISO;
            wait_clk(HALF);
            SCLK = 1'b0;
            if (i < 15) MOSI = cmd[14-i];
            wait_clk(HALF);
        end
        SS_n = 1'b1;
        MOSI = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic do_frame(input logic [15:0] cmd, input string tag);
        logic [15:0] exp;
        logic [15:0] resp;
        exp = {4'h0, ref_val(ptr_m)};
        spi_frame(cmd, 16, resp);
        check_val(tag, resp, exp);
        ptr_m = cmd[13:11];
    endtask

    initial begin
        logic [15:0] resp;
        logic [15:0] cmd;
        ptr_m = 3'd0;

        rst_n = 1'b0;
        wait_clk(5);
        check_val("miso_in_reset", {15'h0, MISO}, 16'h0);
        rst_n = 1'b1;
        wait_clk(5);
        check_val("miso_after_reset", {15'h0, MISO}, 16'h0);

        ld_cell_lft = 12'h14A;
        do_frame(16'h2000, "first_frame_ch0");

        ld_cell_rght = 12'h14A;
        steerPot     = 12'h800;
        batt         = 12'hC00;
        do_frame(16'h2800, "ch4_rght");
        do_frame(16'h3000, "ch5_steer");
        do_frame(16'h0000, "ch6_batt");
        check_val("miso_idle", {15'h0, MISO}, 16'h0);

        do_frame(16'h1000, "ch0_again");
        do_frame(16'h2000, "ch2_zero");

        // ptr now 4; an aborted frame requesting 6 must not move it
        spi_frame(16'h3000, 8, resp);
`ifdef ADC128S_FC_PROTO_CHK_EN
        check_val("err_cnt_short", {8'h0, dut.err_cnt_q}, 16'h0001);
`endif
        do_frame(16'h3000, "after_abort_ch4");

        fork
            do_frame(16'h3000, "batt_midframe_old");
            begin
                wait_clk(100);
                batt = 12'h123;
            end
        join
        do_frame(16'h0000, "batt_new");

        do_frame(16'h2800, "sel_ch5");
        SS_n = 1'b0;
        MOSI = 1'b1;
        wait_clk(HALF);
        for (int i = 0; i < 4; i++) sclk_pulse();
        rst_n = 1'b0;
        wait_clk(2);
        check_val("miso_rst_midframe", {15'h0, MISO}, 16'h0);
        SS_n = 1'b1;
        MOSI = 1'b0;
        SCLK = 1'b0;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(HALF);
        check_val("miso_after_rst_release", {15'h0, MISO}, 16'h0);
        ptr_m = 3'd0;
        do_frame(16'h2000, "post_reset_ch0");

        for (int n = 0; n < 40; n++) begin
            ld_cell_lft  = 12'($urandom);
            ld_cell_rght = 12'($urandom);
            steerPot     = 12'($urandom);
            batt         = 12'($urandom);
            cmd = 16'($urandom) & 16'h3FFF;
            if ($urandom_range(0, 5) == 0) begin
                spi_frame(cmd, $urandom_range(1, 15), resp);
            end else begin
                do_frame(cmd, $sformatf("rand_%0d", n));
            end
        end
        check_val("miso_idle_end", {15'h0, MISO}, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc128s_fc.md
# adc128s_fc

Behavioural/synthesizable model of an 8-channel, 12-bit ADC128S-style SPI A2D converter used in the Segway system bench. It sits between the Segway's A2D SPI master and four analog stimulus values: left load cell, right load cell, steering potentiometer and battery. Each 16-bit SPI frame carries a channel-select command on MOSI while MISO returns the conversion for the channel selected in the previous frame.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on posedge clk.
- rst_n  input  1  reset, synchronous, active-low.
- SS_n  input  1  SPI slave select from master, active-low, frames one transaction.
- SCLK  input  1  SPI clock from master, mode 0 (idle low), asynchronous to clk.
- MOSI  input  1  command bit from master, sampled on SCLK rise.
- MISO  output  1  result bit to master, changes after SCLK fall.
- ld_cell_lft  input  12  value returned for channel 0.
- ld_cell_rght  input  12  value returned for channel 4.
- steerPot  input  12  value returned for channel 5.
- batt  input  12  value returned for channel 6.

## Operation
- SCLK and SS_n are each double-flopped into the clk domain, plus one history flop; edges are detected on the synchronized versions only.
- Command word (MSB first): bits [15:14] don't-care, [13:11] channel, [10:0] don't-care.
- Channel map: 0→ld_cell_lft, 4→ld_cell_rght, 5→steerPot, 6→batt; channels 1,2,3,7 return 12'h000.
- chnl_ptr (3 bits) holds the channel to report in the next frame; reset value 0.
- SS_n fall: tx_shft ← {4'h0, value(chnl_ptr)} sampled that cycle; rx_shft ← 0; bit_cnt ← 0.
- SCLK rise while SS_n low: rx_shft ← {rx_shft[14:0], MOSI}; bit_cnt increments, saturating at 16.
- SCLK fall while SS_n low, after at least one rise in the frame: tx_shft ← {tx_shft[14:0], 1'b0}.
- MISO = tx_shft[15] while synchronized SS_n low; 1'b0 otherwise.
- SS_n rise: if bit_cnt == 16, chnl_ptr ← rx_shft[13:11]; otherwise chnl_ptr is unchanged (aborted frame).
- Values are captured only at the SS_n fall; input changes mid-frame do not affect the frame in flight.
- SCLK edges while SS_n high are ignored.
- Reset values: MISO 0, tx_shft 0, rx_shft 0, bit_cnt 0, chnl_ptr 0, sync flops 1 for SS_n and 0 for SCLK.
- Reset asserted mid-frame: all state returns to reset values on the next clk edge; the frame is discarded.

## Timing
- Edge detection latency: 3 clk from an external SCLK or SS_n edge to the resulting state update.
- MISO is valid 3 clk after the SS_n fall and 3 clk after each SCLK fall.
- The master's SCLK half-period must be at least 8 clk; the Segway master uses clk/32.
- The first frame after reset returns channel 0 data (ld_cell_lft).
- Data latency is one frame: a request issued in frame N is answered in frame N+1.

## Configuration
- Macro: ADC128S_FC_PROTO_CHK_EN.
- Defined: the model flags protocol errors.
  - An SS_n rise with bit_cnt ≠ 16 reports $error("ADC128S: short frame").
  - Command bits [15:14] ≠ 0 report $error.
  - Each error increments an internal 8-bit err_cnt, reset 0, saturating at 255.
- Undefined: no checks and no err_cnt. Functional behaviour is identical either way.

## Structure
- Package adc128s_pkg holds:
  - localparams CH_LFT=3'd0, CH_RGHT=3'd4, CH_STEER=3'd5, CH_BATT=3'd6, FRAME_BITS=16.
  - typedef logic [11:0] adc_val_t.
- Sub-module spi_edge_sync: double-flop plus edge detect. Instanced once for SCLK (rise/fall pulses) and once for SS_n (fall/rise pulses).
- Top level holds the shift registers, bit_cnt, chnl_ptr and the channel mux.

## Test plan
- After reset, ld_cell_lft=330 (12'h14A): frame with cmd 16'h2000 → MISO returns 16'h014A; chnl_ptr becomes 4.
- ld_cell_rght=12'h14A, steerPot=12'h800, batt=12'hC00: frames with cmds 0x2800, 0x3000, 0x0000 in sequence → frames 2, 3, 4 return 0x014A (channel 4), 0x0800 (channel 5), 0x0C00 (channel 6).
- Select channel 2 (cmd 0x1000) → next frame returns 16'h0000.
- Abort a frame after 8 SCLK rises with cmd 0x3000 → chnl_ptr unchanged. With ADC128S_FC_PROTO_CHK_EN defined, err_cnt=1.
- Change batt from 12'hC00 to 12'h123 mid-frame → current frame returns 0x0C00; the following batt request returns 0x0123.
- Assert rst_n low mid-frame, then release → MISO 0, and the next frame returns channel 0 data.
